// File: rtl/dma_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dma_pkg
// Brief    : Shared types and constants for the fly-by DMA channel family.
// Revision : 1.0 - initial release
// ============================================================================
package dma_pkg;

    localparam int DEF_ADDR_W  = 16;
    localparam int DEF_CNT_W   = 8;
    localparam int DEF_TIMEOUT = 15;

    // Peripheral IO window; memory addresses issued by a channel must avoid it.
    localparam int IO_FIRST = 1001;
    localparam int IO_LAST  = 1032;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        HOLD_REQ = 3'd1,
        ACK      = 3'd2,
        STROBE   = 3'd3,
        RELEASE  = 3'd4,
        NEXT     = 3'd5,
        DONE     = 3'd6,
        ABORT    = 3'd7
    } dma_state_e;

endpackage
`default_nettype wire

// File: rtl/dma_timeout_cnt.sv
`default_nettype none
// ============================================================================
// Module   : dma_timeout_cnt
// Brief    : Loadable down-counter that flags expiry when it reaches zero.
// Revision : 1.0 - initial release
// ============================================================================
module dma_timeout_cnt #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             en_i,
    output logic             expire_o
);

    logic [WIDTH-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign expire_o = (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/dma_fly_channel.sv
`default_nettype none
// ============================================================================
// Module   : dma_fly_channel
// Brief    : Single-channel fly-by DMA (IO-to-memory) with HOLD/HLDA bus
//            takeover and IReady/TReady four-phase memory handshake.
// Revision : 1.0 - initial release
// ============================================================================
module dma_fly_channel
    import dma_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int CNT_W   = DEF_CNT_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_load,
    input  logic [ADDR_W-1:0] cfg_base,
    input  logic [CNT_W-1:0]  cfg_count,
    input  logic              DREQ,
    output logic              DACK,
    output logic              hold,
    input  logic              hlda,
    output logic [ADDR_W-1:0] addr_out,
    output logic              addr_oe,
    output logic              mem_wr,
    output logic              IReady,
    input  logic              TReady,
    output logic              busy,
    output logic              tc,
    output logic              err
);

    localparam int              TO_W    = $clog2(TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_LOAD = TO_W'(TIMEOUT - 1);

    dma_state_e        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              armed_q, armed_d;
    logic              err_q, err_d;
    logic              to_load, to_en, to_expire;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
            armed_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            armed_q <= armed_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        armed_d = armed_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (cfg_load) begin
                    addr_d  = cfg_base;
                    cnt_d   = cfg_count;
                    armed_d = (cfg_count != '0);
                    err_d   = 1'b0;
                end
                if (armed_q && DREQ) state_d = HOLD_REQ;
            end
            HOLD_REQ: if (hlda) state_d = ACK;
            ACK:      state_d = hlda ? STROBE : ABORT;
            STROBE: begin
                if (!hlda)          state_d = ABORT;
                else if (TReady)    state_d = RELEASE;
                else if (to_expire) state_d = ABORT;
            end
            RELEASE: begin
                if (!hlda)          state_d = ABORT;
                else if (!TReady)   state_d = NEXT;
                else if (to_expire) state_d = ABORT;
            end
            NEXT: begin
                // The byte is complete here, so the counters advance even if
                // the grant was lost in this cycle.
                addr_d = addr_q + 1'b1;
                cnt_d  = cnt_q - 1'b1;
                if (cnt_d == '0)  state_d = DONE;
                else if (!hlda)   state_d = ABORT;
                else if (DREQ)    state_d = ACK;
                else              state_d = IDLE;
            end
            DONE: begin
                armed_d = 1'b0;
                state_d = IDLE;
            end
            ABORT:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (state_d == ABORT) begin
            err_d   = 1'b1;
            armed_d = 1'b0;
        end
    end

    // Fresh timeout window on every entry to STROBE or RELEASE.
    assign to_load = (state_d != state_q) && ((state_d == STROBE) || (state_d == RELEASE));
    assign to_en   = (state_q == STROBE) || (state_q == RELEASE);

    dma_timeout_cnt #(
        .WIDTH (TO_W)
    ) u_timeout (
        .clk        (clk),
        .rst        (rst),
        .load_i     (to_load),
        .load_val_i (TO_LOAD),
        .en_i       (to_en),
        .expire_o   (to_expire)
    );

    assign hold     = (state_q != IDLE) && (state_q != ABORT);
    assign DACK     = (state_q == ACK) || (state_q == STROBE) || (state_q == RELEASE);
    assign addr_oe  = DACK;
    assign mem_wr   = addr_oe;
    assign IReady   = (state_q == STROBE);
    assign tc       = (state_q == DONE);
    assign addr_out = addr_oe ? addr_q : '0;
    assign busy     = armed_q || (state_q != IDLE);
    assign err      = err_q;

endmodule
`default_nettype wire

// File: tb/tb_dma_fly_channel.sv
`default_nettype none
// ============================================================================
// Module   : tb_dma_fly_channel
// Brief    : Self-checking bench: directed scenarios plus randomized jobs
//            scored against an address/terminal-count transaction model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dma_fly_channel;
    import dma_pkg::*;

    logic        clk = 1'b0;
    logic        rst, cfg_load, DREQ, hlda, TReady;
    logic [15:0] cfg_base;
    logic [7:0]  cfg_count;
    logic        DACK, hold, addr_oe, mem_wr, IReady, busy, tc, err;
    logic [15:0] addr_out;

    int total = 0;
    int bad   = 0;

    // Environment knobs: memory mode 0=zero-wait, 1=random wait, 2=never answers
    int   mem_mode = 0;
    int   wlim = 0, wcnt = 0;
    int   glat = 0, gcnt = 0;
    logic tr_q;

    logic [15:0] exp_q[$];
    int          rise_cyc[$];
    int          cyc = 0, tc_cnt = 0, tc_cyc = 0;
    logic        p_ir = 1'b0, p_dack = 1'b0, p_tc = 1'b0;

    dma_fly_channel dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_load  (cfg_load),
        .cfg_base  (cfg_base),
        .cfg_count (cfg_count),
        .DREQ      (DREQ),
        .DACK      (DACK),
        .hold      (hold),
        .hlda      (hlda),
        .addr_out  (addr_out),
        .addr_oe   (addr_oe),
        .mem_wr    (mem_wr),
        .IReady    (IReady),
        .TReady    (TReady),
        .busy      (busy),
        .tc        (tc),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // CPU grants the bus glat cycles after hold, withdraws once hold drops.
    always @(posedge clk) begin
        if (rst || !hold) begin
            hlda <= 1'b0;
            gcnt <= 0;
        end else if (!hlda) begin
            if (gcnt >= glat) hlda <= 1'b1;
            else gcnt <= gcnt + 1;
        end
    end

    // Wait-state memory: follows IReady after wlim+1 cycles in each direction.
    always @(posedge clk) begin
        if (rst) begin
            tr_q <= 1'b0;
            wcnt <= 0;
        end else if (IReady != tr_q) begin
            if (wcnt >= wlim) begin
                tr_q <= IReady;
                wcnt <= 0;
            end else begin
                wcnt <= wcnt + 1;
            end
        end else begin
            wcnt <= 0;
        end
    end

    assign TReady = (mem_mode == 0) ? IReady : (mem_mode == 1) ? tr_q : 1'b0;

    // Scoreboard: every IReady rise must carry the next expected address.
    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            check_value("memwr_eq_oe", mem_wr, addr_oe);
            if (addr_oe)
                check_value("io_window", (int'(addr_out) >= IO_FIRST) && (int'(addr_out) <= IO_LAST), 1'b0);
            if (IReady && !p_ir) begin
                check_value("dack_leads_iready", {p_dack, p_ir}, 2'b10);
                if (exp_q.size() != 0) check_value("addr", addr_out, exp_q.pop_front());
                else                   check_value("extra_byte_qsize", exp_q.size(), 1);
                rise_cyc.push_back(cyc);
            end
            if (tc) begin
                tc_cnt++;
                tc_cyc = cyc;
            end
            if (p_tc) check_value("tc_then_hold_low", {tc, hold}, 2'b00);
            p_ir   = IReady;
            p_dack = DACK;
            p_tc   = tc;
        end else begin
            p_ir   = 1'b0;
            p_dack = 1'b0;
            p_tc   = 1'b0;
        end
    end

    task automatic do_load(input logic [15:0] base, input logic [7:0] count);
        cfg_base  = base;
        cfg_count = count;
        cfg_load  = 1'b1;
        for (int i = 0; i < int'(count); i++) exp_q.push_back(base + 16'(i));
        tick();
        cfg_load  = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while (busy && n < budget) begin
            tick();
            n++;
        end
        check_value(tag, busy, 1'b0);
    endtask

    task automatic pulse_dreq();
        DREQ = 1'b1;
        tick();
        DREQ = 1'b0;
    endtask

    function automatic logic [31:0] all_outs();
        return {DACK, hold, addr_out, addr_oe, mem_wr, IReady, busy, tc, err};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int   n, falls, nr;
        logic prev, any_hold;

        rst = 1'b1; cfg_load = 1'b0; cfg_base = '0; cfg_count = '0; DREQ = 1'b0;
        repeat (3) tick();
        check_value("reset_outputs", all_outs(), 32'h0);
        rst = 1'b0;
        tick();
        check_value("idle_outputs", all_outs(), 32'h0);

        // Demand mode, zero-wait memory
        mem_mode = 0; glat = 0; tc_cnt = 0; rise_cyc.delete();
        do_load(16'h0100, 8'd3);
        DREQ = 1'b1;
        tick();
        check_value("dreq_to_hold", hold, 1'b1);
        wait_idle("t1_done", 100);
        DREQ = 1'b0;
        check_value("t1_exp_left", exp_q.size(), 0);
        check_value("t1_tc_cnt", tc_cnt, 1);
        check_value("t1_bytes", rise_cyc.size(), 3);
        if (rise_cyc.size() == 3) begin
            check_value("t1_space01", rise_cyc[1] - rise_cyc[0], 4);
            check_value("t1_space12", rise_cyc[2] - rise_cyc[1], 4);
            check_value("t1_tc_lat", tc_cyc - rise_cyc[2], 3);
        end
        check_value("t1_hold_busy", {hold, busy}, 2'b00);

        // Single-cycle DREQ pulses: one byte per pulse, bus released between
        tc_cnt = 0; rise_cyc.delete(); glat = 2;
        do_load(16'h0200, 8'd2);
        pulse_dreq();
        n = 0;
        while (!(rise_cyc.size() >= 1 && !hold) && n < 60) begin
            tick();
            n++;
        end
        repeat (3) tick();
        check_value("t2_hold_rel", hold, 1'b0);
        check_value("t2_busy_arm", busy, 1'b1);
        check_value("t2_one_byte", rise_cyc.size(), 1);
        check_value("t2_no_tc", tc_cnt, 0);
        pulse_dreq();
        wait_idle("t2_done", 100);
        check_value("t2_bytes", rise_cyc.size(), 2);
        check_value("t2_tc_cnt", tc_cnt, 1);
        check_value("t2_exp_left", exp_q.size(), 0);

        // Address wrap
        tc_cnt = 0; glat = 0;
        do_load(16'hFFFF, 8'd2);
        DREQ = 1'b1;
        wait_idle("t3_done", 100);
        DREQ = 1'b0;
        check_value("t3_exp_left", exp_q.size(), 0);
        check_value("t3_tc_cnt", tc_cnt, 1);

        // Randomized jobs
        for (int j = 0; j < 8; j++) begin
            mem_mode = int'($urandom_range(0, 1));
            wlim     = int'($urandom_range(0, 4));
            glat     = int'($urandom_range(0, 3));
            tc_cnt   = 0;
            do_load(16'($urandom_range(16'h0500, 16'hF000)), 8'($urandom_range(1, 6)));
            n = 0;
            while (busy && n < 1500) begin
                DREQ = ($urandom_range(0, 3) != 0);
                tick();
                n++;
            end
            DREQ = 1'b0;
            check_value("rj_done", busy, 1'b0);
            check_value("rj_exp_left", exp_q.size(), 0);
            check_value("rj_tc_cnt", tc_cnt, 1);
            check_value("rj_err", err, 1'b0);
        end

        // Memory never answers: timeout abort
        mem_mode = 2; glat = 0; tc_cnt = 0;
        do_load(16'h3000, 8'd2);
        DREQ = 1'b1;
        n = 0;
        while (!IReady && n < 50) begin
            tick();
            n++;
        end
        n = 0;
        while (IReady && n < 100) begin
            n++;
            tick();
        end
        check_value("t4_strobe_len", n, 15);
        check_value("t4_abort_err", err, 1'b1);
        check_value("t4_abort_bus", {DACK, hold, IReady, addr_oe}, 4'b0000);
        repeat (5) tick();
        check_value("t4_idle_busy", {busy, hold}, 2'b00);
        check_value("t4_err_sticky", err, 1'b1);
        check_value("t4_no_tc", tc_cnt, 0);
        exp_q.delete();
        DREQ = 1'b0; mem_mode = 0;
        do_load(16'h3000, 8'd0);
        check_value("t4_err_clr", err, 1'b0);

        // Zero count never arms
        DREQ = 1'b1; any_hold = 1'b0;
        do_load(16'h4000, 8'd0);
        repeat (10) begin
            tick();
            any_hold |= hold;
        end
        check_value("t5_hold", any_hold, 1'b0);
        check_value("t5_busy", busy, 1'b0);
        check_value("t5_no_tc", tc_cnt, 0);
        DREQ = 1'b0;

        // Reset during RELEASE of byte 2 of 4
        mem_mode = 1; wlim = 3; glat = 1;
        do_load(16'h5000, 8'd4);
        DREQ = 1'b1;
        falls = 0; prev = 1'b0; n = 0;
        while (falls < 2 && n < 200) begin
            tick();
            if (prev && !IReady) falls++;
            prev = IReady;
            n++;
        end
        check_value("t6_in_release", {DACK, IReady}, 2'b10);
        rst = 1'b1;
        tick();
        check_value("t6_rst_outputs", all_outs(), 32'h0);
        rst = 1'b0;
        exp_q.delete();
        tc_cnt = 0; any_hold = 1'b0; nr = rise_cyc.size();
        repeat (20) begin
            tick();
            any_hold |= hold;
        end
        check_value("t6_no_hold", any_hold, 1'b0);
        check_value("t6_no_busy", busy, 1'b0);
        check_value("t6_no_bytes", rise_cyc.size(), nr);
        check_value("t6_no_tc_err", {tc_cnt != 0, err}, 2'b00);
        DREQ = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
